// File: rtl/mem_port_pkg.sv
// mem_port_pkg: shared access-size/state types, f3 codes and alignment helpers for mem_port.
// Build option: MEM_MISALIGN_TRAP_EN turns misaligned accesses into faults instead of forcing alignment.
package mem_port_pkg;
   typedef enum logic [1:0] {MEM_B, MEM_H, MEM_W} mem_size_t;
   typedef enum logic [1:0] {MP_IDLE, MP_REQ, MP_RESP, MP_FIN} memport_state_t;
   localparam logic [2:0] F3_LB = 3'b000, F3_LH = 3'b001, F3_LW = 3'b010, F3_LBU = 3'b100, F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB = 3'b000, F3_SH = 3'b001, F3_SW = 3'b010;
`ifdef MEM_MISALIGN_TRAP_EN
   localparam bit TRAP_EN = 1'b1;
`else
   localparam bit TRAP_EN = 1'b0;
`endif
   function automatic mem_size_t f3_size(input logic [1:0] f);
      return f == 2'd0 ? MEM_B : f == 2'd1 ? MEM_H : MEM_W;
   endfunction
   function automatic logic misaligned(input mem_size_t s, input logic [1:0] a);
      return (s == MEM_H && a[0]) || (s == MEM_W && a != 2'b00);
   endfunction
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: byte-lane strobes, store replication, load shift/extension and misalign detect.
// Without MEM_MISALIGN_TRAP_EN the low offset bits are masked down to the access size.
module mem_lane_align
   import mem_port_pkg::*;
(
   input  mem_size_t   size,
   input  logic        uns,
   input  logic [1:0]  off,
   input  logic [31:0] wdata,
   input  logic [31:0] rword,
   output logic [3:0]  strb,
   output logic [31:0] wlanes,
   output logic [31:0] rfmt,
   output logic        misalign
);
   logic [1:0]  eo;
   logic [31:0] sh;
   assign misalign = misaligned(size, off);
   assign eo = TRAP_EN ? off : size == MEM_W ? 2'b00 : size == MEM_H ? {off[1], 1'b0} : off;
   assign strb = size == MEM_W ? 4'b1111 : size == MEM_H ? 4'b0011 << eo : 4'b0001 << eo;
   assign wlanes = size == MEM_W ? wdata : size == MEM_H ? {2{wdata[15:0]}} : {4{wdata[7:0]}};
   assign sh = rword >> {eo, 3'b000};
   assign rfmt = size == MEM_W ? sh :
                 size == MEM_H ? {{16{sh[15] & ~uns}}, sh[15:0]} :
                                 {{24{sh[7] & ~uns}}, sh[7:0]};
endmodule

// File: rtl/mem_port.sv
// mem_port: memory access FSM between control unit rd/wr pulses and a valid/ready + rvalid bus.
// Build option: MEM_MISALIGN_TRAP_EN (see mem_port_pkg) makes misaligned accesses fault without a bus cycle.
module mem_port
   import mem_port_pkg::*;
#(
   parameter int          AW          = 32,
   parameter logic [31:0] RESET_RDATA = 32'h0000_0013
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_rd,
   input  logic          req_wr,
   input  logic          req_data,
   input  logic [2:0]    req_f3,
   input  logic [31:0]   req_addr,
   input  logic [31:0]   req_wdata,
   output logic          done,
   output logic [31:0]   rdata,
   output logic          busy,
   output logic          fault,
   output logic          bus_valid,
   input  logic          bus_ready,
   output logic          bus_we,
   output logic [AW-1:0] bus_addr,
   output logic [3:0]    bus_wstrb,
   output logic [31:0]   bus_wdata,
   input  logic          bus_rvalid,
   input  logic [31:0]   bus_rdata
);
   memport_state_t state;
   logic [AW-1:0]  a_addr;
   logic [31:0]    a_wdata, wlanes, rfmt;
   mem_size_t      a_size, n_size, al_size;
   logic           a_uns, trap, req, accept, mis, go_trap;
   logic [1:0]     al_off;
   logic [3:0]     strb;
   assign req = req_rd | req_wr;
   assign accept = state == MP_IDLE || (state == MP_FIN && done);
   assign n_size = req_data ? f3_size(req_f3[1:0]) : MEM_W;
   // While accepting, the aligner looks at the incoming request so misalignment is known up front.
   assign al_size = accept ? n_size : a_size;
   assign al_off = accept ? req_addr[1:0] : a_addr[1:0];
   assign go_trap = TRAP_EN && mis;
   assign busy = state != MP_IDLE;
   assign bus_addr = {a_addr[AW-1:2], 2'b00};
   assign bus_wstrb = bus_valid && bus_we ? strb : 4'b0000;
   assign bus_wdata = wlanes;
   mem_lane_align u_align (
      .size(al_size), .uns(a_uns), .off(al_off), .wdata(a_wdata), .rword(bus_rdata),
      .strb(strb), .wlanes(wlanes), .rfmt(rfmt), .misalign(mis)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= MP_IDLE;
         done      <= 1'b0;
         fault     <= 1'b0;
         bus_valid <= 1'b0;
         bus_we    <= 1'b0;
         rdata     <= RESET_RDATA;
         trap      <= 1'b0;
         a_addr    <= '0;
         a_size    <= MEM_W;
         a_uns     <= 1'b0;
         a_wdata   <= '0;
      end else begin
         done  <= 1'b0;
         fault <= 1'b0;
         case (state)
            MP_IDLE, MP_FIN:
               if (trap) begin
                  done  <= 1'b1;
                  fault <= 1'b1;
                  trap  <= 1'b0;
                  state <= MP_IDLE;
               end else if (accept && req) begin
                  a_addr  <= req_addr[AW-1:0];
                  a_size  <= n_size;
                  a_uns   <= req_data & req_f3[2];
                  a_wdata <= req_wdata;
                  bus_we  <= req_wr;
                  if (go_trap) begin
                     trap  <= 1'b1;
                     state <= MP_FIN;
                  end else begin
                     bus_valid <= 1'b1;
                     state     <= MP_REQ;
                  end
               end else begin
                  state <= MP_IDLE;
               end
            MP_REQ:
               if (bus_ready) begin
                  bus_valid <= 1'b0;
                  if (bus_we || bus_rvalid) begin
                     if (!bus_we) rdata <= rfmt;
                     done  <= 1'b1;
                     state <= MP_FIN;
                  end else begin
                     state <= MP_RESP;
                  end
               end
            MP_RESP:
               if (bus_rvalid) begin
                  rdata <= rfmt;
                  done  <= 1'b1;
                  state <= MP_FIN;
               end
            default: state <= MP_IDLE;
         endcase
      end
   end
`ifndef SYNTHESIS
   // A request outside IDLE or the done cycle is dropped; flag it in simulation.
   assert property (@(posedge clk) disable iff (rst) req |-> accept);
`endif
endmodule
